// File: rtl/pruebas7_timer_sched.sv
// -----------------------------------------------------------------------------
// pruebas7_timer_sched
// Sequencer and tick scheduler for the system interval timer. Acts as an
// Avalon-MM write-only master on the timer register slave: arms the timer,
// acknowledges each timeout interrupt and turns every acknowledged timeout
// into a one-cycle tick. Derives NCH periodic channel pulses from per-channel
// divisors and raises a sticky watchdog flag when tmr_irq goes missing.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   enable         1 runs the scheduler, 0 disarms the timer interrupt
//   ch_div         channel i divisor in [i*DIV_W +: DIV_W], 0 disables it
//   tmr_address    timer register address (registered)
//   tmr_chipselect timer chip select (registered)
//   tmr_write_n    timer write strobe, active low (registered)
//   tmr_writedata  timer write data (registered)
//   tmr_irq        timer interrupt, level
//   tick           one-cycle pulse per acknowledged timeout
//   ch_fire        one-cycle pulse per channel event
//   tick_count     acknowledged-timeout count, wraps
//   wd_error       sticky watchdog-expired flag
// -----------------------------------------------------------------------------
module pruebas7_timer_sched #(
    parameter int unsigned     NCH      = 4,
    parameter int unsigned     DIV_W    = 8,
    parameter int unsigned     WD_W     = 26,
    parameter logic [WD_W-1:0] WD_LIMIT = 26'h3000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NCH*DIV_W-1:0] ch_div,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic                 tmr_irq,
    output logic                 tick,
    output logic [NCH-1:0]       ch_fire,
    output logic [15:0]          tick_count,
    output logic                 wd_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM_CTL, S_ARM_RLD, S_WAIT, S_ACK, S_SETTLE, S_DISARM
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               tick_q, tick_d;
    logic [NCH-1:0]     fire_q, fire_d;
    logic [15:0]        tcnt_q, tcnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
    logic [DIV_W-1:0]   chcnt_q [NCH];
    logic [DIV_W-1:0]   chcnt_d [NCH];

    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        fire_d  = '0;
        tcnt_d  = tcnt_q;
        wd_d    = wd_q;
        err_d   = err_q;
        chcnt_d = chcnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ARM_CTL;
            end
            S_ARM_CTL: begin
                err_d   = 1'b0;
                wd_d    = '0;
                tcnt_d  = '0;
                chcnt_d = '{default: '0};
                state_d = S_ARM_RLD;
            end
            S_ARM_RLD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (tmr_irq) begin
                    state_d = S_ACK;
                end else if (!enable) begin
                    state_d = S_DISARM;
                end else if (wd_q == WD_LIMIT - 1'b1) begin
                    err_d = 1'b1;
                    wd_d  = '0;
                end
            end
            S_ACK: begin
                // Tick, channel events and count are computed on the edge into
                // SETTLE so they become visible together in the SETTLE cycle.
                wd_d    = '0;
                state_d = S_SETTLE;
                tick_d  = 1'b1;
                tcnt_d  = tcnt_q + 1'b1;
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (ch_div[i*DIV_W +: DIV_W] == '0) begin
                        chcnt_d[i] = '0;
                    end else if (({1'b0, chcnt_q[i]} + 1'b1) >= {1'b0, ch_div[i*DIV_W +: DIV_W]}) begin
                        fire_d[i]  = 1'b1;
                        chcnt_d[i] = '0;
                    end else begin
                        chcnt_d[i] = chcnt_q[i] + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                state_d = S_WAIT;
            end
            S_DISARM: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so each
    // write appears in exactly the cycle its state is occupied.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            S_ARM_CTL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'd1; end
            S_ARM_RLD: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; end
            S_ACK:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
            S_DISARM:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= '0;
            tick_q  <= 1'b0;
            fire_q  <= '0;
            tcnt_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            chcnt_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
            tick_q  <= tick_d;
            fire_q  <= fire_d;
            tcnt_q  <= tcnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            chcnt_q <= chcnt_d;
        end
    end

    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = wdata_q;
    assign tick           = tick_q;
    assign ch_fire        = fire_q;
    assign tick_count     = tcnt_q;
    assign wd_error       = err_q;

endmodule
